// File: rtl/pll_lock_sequencer.sv
// PLL power-up / relock sequencer: pulses the PLL reset, waits for a stable lock with a
// timeout and retry budget, then releases the system reset; re-sequences on lock loss.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int SETTLE_CYCLES = 256,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 13,
    parameter int RETRY_W       = 2
) (
    input  logic               REFERENCECLK,
    input  logic               RESET,
    input  logic               LOCK,
    input  logic               RELOCK_REQ,
    output logic               PLL_RESETB,
    output logic               SYS_RESETN,
    output logic               READY,
    output logic               FAULT,
    output logic [RETRY_W-1:0] RETRY_CNT,
    output logic [2:0]         STATE
);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_SETTLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [RETRY_W-1:0]   retry_nxt;
    logic                 lock_p0, lock_p1;

    // LOCK is asynchronous to the reference clock; lock_p1 is the only copy the FSM uses.
    always_ff @(posedge REFERENCECLK or negedge RESET) begin
        if (!RESET) begin
            lock_p0 <= 1'b0;
            lock_p1 <= 1'b0;
        end else begin
            lock_p0 <= LOCK;
            lock_p1 <= lock_p0;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        retry_nxt = RETRY_CNT;
        case (state)
            S_PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            S_WAIT_LOCK: begin
                // A lock arriving on the timeout cycle takes priority over the retry.
                if (lock_p1) begin
                    state_nxt = S_SETTLE;
                    cnt_nxt   = '0;
                end else if (cnt == TO_LAST) begin
                    cnt_nxt = '0;
                    if (RETRY_CNT == RETRY_MAX) begin
                        state_nxt = S_FAULT;
                    end else begin
                        retry_nxt = RETRY_CNT + 1'b1;
                        state_nxt = S_PLL_RST;
                    end
                end
            end
            S_SETTLE: begin
                if (!lock_p1) begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == SETTLE_LAST) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end
            end
            S_RUN: begin
                cnt_nxt = '0;
                if (!lock_p1 || RELOCK_REQ) begin
                    state_nxt = S_PLL_RST;
                end
            end
            S_FAULT: begin
                cnt_nxt = '0;
                if (RELOCK_REQ) begin
                    state_nxt = S_PLL_RST;
                    retry_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_PLL_RST;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge REFERENCECLK or negedge RESET) begin
        if (!RESET) begin
            state      <= S_PLL_RST;
            cnt        <= '0;
            RETRY_CNT  <= '0;
            PLL_RESETB <= 1'b0;
            SYS_RESETN <= 1'b0;
            READY      <= 1'b0;
            FAULT      <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            RETRY_CNT  <= retry_nxt;
            PLL_RESETB <= (state_nxt == S_WAIT_LOCK) || (state_nxt == S_SETTLE) ||
                          (state_nxt == S_RUN);
            SYS_RESETN <= (state_nxt == S_RUN);
            READY      <= (state_nxt == S_RUN);
            FAULT      <= (state_nxt == S_FAULT);
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: cycle model feeds a scoreboard queue, plus directed timing checks.
module tb_pll_lock_sequencer;

    localparam int RST  = 4;
    localparam int TO   = 32;
    localparam int SET  = 8;
    localparam int MAXR = 2;

    logic       clk, rst_n, lock, relock;
    logic       pll_resetb, sys_resetn, ready, fault;
    logic [1:0] retry_cnt;
    logic [2:0] state;

    pll_lock_sequencer #(
        .RST_CYCLES(RST), .LOCK_TIMEOUT(TO), .SETTLE_CYCLES(SET),
        .MAX_RETRY(MAXR), .CNT_W(13), .RETRY_W(2)
    ) dut (
        .REFERENCECLK(clk), .RESET(rst_n), .LOCK(lock), .RELOCK_REQ(relock),
        .PLL_RESETB(pll_resetb), .SYS_RESETN(sys_resetn), .READY(ready),
        .FAULT(fault), .RETRY_CNT(retry_cnt), .STATE(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct packed {
        logic       prb;
        logic       srn;
        logic       rdy;
        logic       flt;
        logic [1:0] rc;
        logic [2:0] st;
    } obs_t;

    obs_t exp_q[$];

    // Behavioural reference: state, counter, retries and the two-stage lock delay line.
    int         m_st = 0;
    int         m_cnt = 0;
    int         m_retry = 0;
    logic       m_s1 = 1'b0, m_s2 = 1'b0;

    task automatic model_step();
        logic lk;
        obs_t e;
        if (!rst_n) begin
            m_st = 0; m_cnt = 0; m_retry = 0; m_s1 = 1'b0; m_s2 = 1'b0;
        end else begin
            lk   = m_s2;
            m_s2 = m_s1;
            m_s1 = lock;
            case (m_st)
                0: if (m_cnt == RST - 1) begin m_st = 1; m_cnt = 0; end else m_cnt++;
                1: begin
                    if (lk) begin m_st = 2; m_cnt = 0; end
                    else if (m_cnt == TO - 1) begin
                        m_cnt = 0;
                        if (m_retry == MAXR) m_st = 4;
                        else begin m_retry++; m_st = 0; end
                    end else m_cnt++;
                end
                2: begin
                    if (!lk) begin m_st = 1; m_cnt = 0; end
                    else if (m_cnt == SET - 1) begin m_st = 3; m_cnt = 0; m_retry = 0; end
                    else m_cnt++;
                end
                3: if (!lk || relock) begin m_st = 0; m_cnt = 0; end
                default: if (relock) begin m_st = 0; m_cnt = 0; m_retry = 0; end
            endcase
        end
        e.prb = rst_n && (m_st == 1 || m_st == 2 || m_st == 3);
        e.srn = rst_n && (m_st == 3);
        e.rdy = rst_n && (m_st == 3);
        e.flt = rst_n && (m_st == 4);
        e.rc  = 2'(m_retry);
        e.st  = 3'(m_st);
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk_eq("sb_pll_resetb", pll_resetb, e.prb);
                chk_eq("sb_sys_resetn", sys_resetn, e.srn);
                chk_eq("sb_ready",      ready,      e.rdy);
                chk_eq("sb_fault",      fault,      e.flt);
                chk_eq("sb_retry_cnt",  retry_cnt,  e.rc);
                chk_eq("sb_state",      state,      e.st);
            end
        end
    end

    task automatic wait_st(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_eq(tag, state, s);
    endtask

    task automatic count_settle(input string tag);
        int n = 0;
        while (state == 3'd2 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk_eq(tag, n, SET);
        chk_eq({tag, "_run"}, state, 3'd3);
        chk_eq({tag, "_srn"}, sys_resetn, 1'b1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_eq({tag, "_prb"},   pll_resetb, 1'b0);
        chk_eq({tag, "_srn"},   sys_resetn, 1'b0);
        chk_eq({tag, "_ready"}, ready,      1'b0);
        chk_eq({tag, "_fault"}, fault,      1'b0);
        chk_eq({tag, "_retry"}, retry_cnt,  2'd0);
        chk_eq({tag, "_state"}, state,      3'd0);
    endtask

    initial begin
        int         n;
        logic [1:0] r;
        rst_n  = 1'b0;
        lock   = 1'b1;
        relock = 1'b0;
        #1;
        chk_reset_vals("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Power-up with LOCK already high
        wait_st(3'd2, 40, "s1_reach_settle");
        count_settle("s1_settle_len");
        chk_eq("s1_retry", retry_cnt, 2'd0);

        // LOCK stuck low: three timeouts then FAULT, cleared by RELOCK_REQ
        lock = 1'b0;
        wait_st(3'd4, 300, "s2_reach_fault");
        chk_eq("s2_fault", fault, 1'b1);
        chk_eq("s2_retry", retry_cnt, 2'd2);
        chk_eq("s2_prb", pll_resetb, 1'b0);
        @(negedge clk); relock = 1'b1;
        @(negedge clk); relock = 1'b0;
        chk_eq("s2_clr_fault", fault, 1'b0);
        chk_eq("s2_clr_retry", retry_cnt, 2'd0);
        chk_eq("s2_clr_state", state, 3'd0);

        // One-cycle lock glitch at settle count 5
        lock = 1'b1;
        wait_st(3'd2, 60, "s3_reach_settle");
        repeat (3) @(negedge clk);
        lock = 1'b0;
        @(negedge clk);
        lock = 1'b1;
        wait_st(3'd1, 10, "s3_back_to_wait");
        chk_eq("s3_srn_low", sys_resetn, 1'b0);
        wait_st(3'd2, 20, "s3_resettle");
        count_settle("s3_resettle_len");

        // Lock loss in RUN
        lock = 1'b0;
        n = 0;
        while (ready == 1'b1 && n < 10) begin @(negedge clk); n++; end
        chk_eq("s4_ready_drop", ready, 1'b0);
        chk_eq("s4_srn_drop", sys_resetn, 1'b0);
        chk_eq("s4_prb_drop", pll_resetb, 1'b0);
        chk_eq("s4_state", state, 3'd0);
        lock = 1'b1;
        wait_st(3'd3, 60, "s4_relocked");
        chk_eq("s4_retry", retry_cnt, 2'd0);

        // RELOCK_REQ in RUN, then ignored in WAIT_LOCK
        @(negedge clk); relock = 1'b1;
        @(negedge clk); relock = 1'b0; lock = 1'b0;
        n = 0;
        while (pll_resetb == 1'b0 && n < 20) begin n++; @(negedge clk); end
        chk_eq("s5_prb_pulse_len", n, RST);
        wait_st(3'd1, 10, "s5_in_wait");
        @(negedge clk); relock = 1'b1;
        @(negedge clk); relock = 1'b0;
        chk_eq("s5_relock_ignored", state, 3'd1);
        @(negedge clk);
        chk_eq("s5_relock_ignored2", state, 3'd1);
        lock = 1'b1;
        wait_st(3'd3, 60, "s5_back_to_run");

        // Lock on the timeout cycle, then reset mid-SETTLE
        lock = 1'b0;
        wait_st(3'd1, 20, "s6_in_wait");
        r = retry_cnt;
        repeat (29) @(negedge clk);
        lock = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_eq("s6_still_wait", state, 3'd1);
        @(negedge clk);
        chk_eq("s6_lock_wins", state, 3'd2);
        chk_eq("s6_retry_kept", retry_cnt, r);
        @(negedge clk);
        chk_eq("s6_pre_rst", state, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("s6_async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
